// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter_if
// Brief    : Requester and transmitter signal bundle for uart_tx_arbiter.
//            The master modport is the arbiter side, slave is the environment.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   REQ_VALID;
    logic [8*NUM_REQ-1:0] REQ_BYTE;
    logic [NUM_REQ-1:0]   REQ_LAST;
    logic [NUM_REQ-1:0]   REQ_READY;
    logic                 TX_DV;
    logic [7:0]           TX_BYTE;
    logic                 TX_DONE;
    logic [NUM_REQ-1:0]   GRANT;
    logic                 BUSY;
    logic                 ERR;

    modport master (
        input  REQ_VALID, REQ_BYTE, REQ_LAST, TX_DONE,
        output REQ_READY, TX_DV, TX_BYTE, GRANT, BUSY, ERR
    );

    modport slave (
        output REQ_VALID, REQ_BYTE, REQ_LAST, TX_DONE,
        input  REQ_READY, TX_DV, TX_BYTE, GRANT, BUSY, ERR
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Round-robin arbiter sharing one UART byte transmitter among
//            NUM_REQ sources, with start-timeout detection.
//            Optional packet lock: define UART_ARB_PKT_LOCK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int START_TIMEOUT = 4
) (
    input  wire logic         CLK,
    input  wire logic         RST,
    uart_tx_arbiter_if.master bus
);
    localparam int               c_IDX_W    = $clog2(NUM_REQ);
    localparam logic [3:0]       c_CNT_LAST = 4'(START_TIMEOUT - 1);
    localparam logic [c_IDX_W:0] c_NUM_REQ  = (c_IDX_W + 1)'(NUM_REQ);

    typedef enum logic [1:0] {
        ST_ARB       = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_LOW  = 2'd2,
        ST_WAIT_HIGH = 2'd3
    } state_t;

    state_t               r_state;
    logic [c_IDX_W-1:0]   r_last;
    logic [3:0]           r_cnt;
    logic                 r_tx_dv;
    logic [7:0]           r_tx_byte;
    logic [NUM_REQ-1:0]   r_grant;

    logic [NUM_REQ-1:0]   w_elig;
    logic [NUM_REQ-1:0]   w_last_onehot;
    logic [NUM_REQ-1:0]   w_win_onehot;
    logic [c_IDX_W-1:0]   w_win;
    logic [c_IDX_W:0]     w_sum;
    logic                 w_found;
    logic                 w_accept;
    logic                 w_err;

    assign w_last_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_last;

`ifdef UART_ARB_PKT_LOCK_EN
    logic r_lock;
    // While a packet is open only its owner (always r_last) may be granted.
    assign w_elig = r_lock ? (bus.REQ_VALID & w_last_onehot) : bus.REQ_VALID;
`else
    logic w_unused_last;
    assign w_unused_last = ^bus.REQ_LAST;
    assign w_elig        = bus.REQ_VALID;
`endif

    // Scan upward from last+1; the previous owner is visited last.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_sum = {1'b0, r_last} + (c_IDX_W + 1)'(k);
            if (w_sum >= c_NUM_REQ) begin
                w_sum = w_sum - c_NUM_REQ;
            end
            if (!w_found && w_elig[w_sum[c_IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_sum[c_IDX_W-1:0];
            end
        end
    end

    assign w_win_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win;
    assign w_accept     = (r_state == ST_ARB) && bus.TX_DONE && w_found;
    // Timeout fires in the cycle the count would reach START_TIMEOUT.
    assign w_err        = (r_state == ST_WAIT_LOW) && bus.TX_DONE && (r_cnt == c_CNT_LAST);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= ST_ARB;
            r_last    <= c_IDX_W'(NUM_REQ - 1);
            r_cnt     <= '0;
            r_tx_dv   <= 1'b0;
            r_tx_byte <= 8'h00;
            r_grant   <= '0;
`ifdef UART_ARB_PKT_LOCK_EN
            r_lock    <= 1'b0;
`endif
        end else begin
            r_tx_dv <= 1'b0;
            case (r_state)
                ST_ARB: begin
                    if (w_accept) begin
                        r_tx_byte <= bus.REQ_BYTE[8*w_win +: 8];
                        r_last    <= w_win;
                        r_grant   <= w_win_onehot;
                        r_tx_dv   <= 1'b1;
                        r_state   <= ST_ISSUE;
`ifdef UART_ARB_PKT_LOCK_EN
                        r_lock    <= ~bus.REQ_LAST[w_win];
`endif
                    end
                end
                ST_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= ST_WAIT_LOW;
                end
                ST_WAIT_LOW: begin
                    if (!bus.TX_DONE) begin
                        r_state <= ST_WAIT_HIGH;
                    end else if (w_err) begin
                        r_state <= ST_ARB;
                        r_grant <= '0;
`ifdef UART_ARB_PKT_LOCK_EN
                        r_lock  <= 1'b0;
`endif
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                ST_WAIT_HIGH: begin
                    if (bus.TX_DONE) begin
                        r_state <= ST_ARB;
                        r_grant <= '0;
                    end
                end
                default: r_state <= ST_ARB;
            endcase
        end
    end

    assign bus.REQ_READY = w_accept ? w_win_onehot : '0;
    assign bus.TX_DV     = r_tx_dv;
    assign bus.TX_BYTE   = r_tx_byte;
    assign bus.GRANT     = r_grant;
    assign bus.BUSY      = (r_state != ST_ARB);
    assign bus.ERR       = w_err;

endmodule
`default_nettype wire
